// File: rtl/npc_ras_unit.sv
// Fetch-PC register and next-PC selection for the 5-stage pipeline, with a
// circular return-address stack shadowing jal / jr $ra pairs.
module npc_ras_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          RAS_DEPTH  = 8,
    parameter int          CNT_W      = 16,
    localparam int         PW         = $clog2(RAS_DEPTH),
    localparam int         CW         = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             req,
    input  logic             eret,
    input  logic [31:0]      EPC,
    input  logic [31:0]      PC_D,
    input  logic [31:0]      rs,
    input  logic             rs_is_ra,
    input  logic [15:0]      imm,
    input  logic [25:0]      ins_index,
    input  logic             isJr,
    input  logic             isJal,
    input  logic             isBranch,
    input  logic             isBranchSuccess,
    output logic [31:0]      PC_F,
    output logic [31:0]      NPC,
    output logic [CW-1:0]    ras_count,
    output logic [31:0]      ras_top,
    output logic             ras_mismatch,
    output logic [CNT_W-1:0] mismatch_cnt
);

    logic [31:0]      pc_f_q, pc_f_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic [31:0]      mem_q [RAS_DEPTH];

    logic        ras_en, push, pop, empty, full;
    logic [31:0] br_off, ret_addr;

    always_comb begin
        br_off   = {{14{imm[15]}}, imm, 2'b00};
        ret_addr = PC_D + 32'd8;
        if (req)
            NPC = EXC_VECTOR;
        else if (eret)
            NPC = EPC;
        else if (isJal)
            NPC = {PC_D[31:28], ins_index, 2'b00};
        else if (isBranch && isBranchSuccess)
            NPC = PC_D + 32'd4 + br_off;
        else if (isJr)
            NPC = rs;
        else
            NPC = pc_f_q + 32'd4;
    end

    // Redirects from req/eret must win over a hazard stall.
    always_comb begin
        pc_f_d = pc_f_q;
        if (req || eret)
            pc_f_d = NPC;
        else if (!stall)
            pc_f_d = NPC;
    end

    always_comb begin
        ras_en = !stall && !req && !eret;
        push   = ras_en && isJal;
        pop    = ras_en && isJr && rs_is_ra && !isJal;
        empty  = (count_q == '0);
        full   = (count_q == CW'(RAS_DEPTH));
        ras_top = empty ? 32'h0 : mem_q[ptr_q];
    end

    // A push on a full stack wraps onto the oldest entry.
    always_comb begin
        ptr_d      = ptr_q;
        count_d    = count_q;
        mismatch_d = 1'b0;
        if (push) begin
            ptr_d = ptr_q + PW'(1);
            if (!full)
                count_d = count_q + CW'(1);
        end else if (pop) begin
            if (empty) begin
                mismatch_d = 1'b1;
            end else begin
                mismatch_d = (mem_q[ptr_q] != rs);
                ptr_d      = ptr_q - PW'(1);
                count_d    = count_q - CW'(1);
            end
        end
        mcnt_d = mcnt_q;
        if (mismatch_d && (mcnt_q != '1))
            mcnt_d = mcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q     <= RESET_PC;
            ptr_q      <= '0;
            count_q    <= '0;
            mismatch_q <= 1'b0;
            mcnt_q     <= '0;
        end else begin
            pc_f_q     <= pc_f_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
            mcnt_q     <= mcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem_q[ptr_d] <= ret_addr;
    end

    assign PC_F         = pc_f_q;
    assign ras_count    = count_q;
    assign ras_mismatch = mismatch_q;
    assign mismatch_cnt = mcnt_q;

endmodule

// File: tb/tb_npc_ras_unit.sv
// Directed bench for npc_ras_unit: table of single-cycle vectors plus
// hand-written multi-cycle sequences for RAS overflow, stall and redirects.
module tb_npc_ras_unit;

    logic        clk, reset, stall, req, eret;
    logic [31:0] EPC, PC_D, rs;
    logic        rs_is_ra;
    logic [15:0] imm;
    logic [25:0] ins_index;
    logic        isJr, isJal, isBranch, isBranchSuccess;
    logic [31:0] PC_F, NPC, ras_top;
    logic [3:0]  ras_count;
    logic        ras_mismatch;
    logic [15:0] mismatch_cnt;

    int errors = 0;
    int checks = 0;

    npc_ras_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret),
        .EPC(EPC), .PC_D(PC_D), .rs(rs), .rs_is_ra(rs_is_ra), .imm(imm),
        .ins_index(ins_index), .isJr(isJr), .isJal(isJal),
        .isBranch(isBranch), .isBranchSuccess(isBranchSuccess),
        .PC_F(PC_F), .NPC(NPC), .ras_count(ras_count), .ras_top(ras_top),
        .ras_mismatch(ras_mismatch), .mismatch_cnt(mismatch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, req, eret;
        logic [31:0] epc, pc_d, rs;
        logic        ra;
        logic [15:0] imm;
        logic [25:0] idx;
        logic        jr, jal, br, brs;
        logic [31:0] e_npc, e_pcf;
        int          e_cnt;
        logic [31:0] e_top;
        logic        e_mm;
        int          e_mcnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t nop(input logic [31:0] pcf, input int cnt,
                                 input logic [31:0] top, input int mcnt);
        vec_t v;
        v = '{stall:0, req:0, eret:0, epc:0, pc_d:0, rs:0, ra:0, imm:0,
              idx:0, jr:0, jal:0, br:0, brs:0, e_npc:pcf + 4,
              e_pcf:pcf + 4, e_cnt:cnt, e_top:top, e_mm:0, e_mcnt:mcnt};
        return v;
    endfunction

    // Inputs are applied 1 time unit after a rising edge.
    task automatic run(input vec_t v, input string tag);
        stall = v.stall; req = v.req; eret = v.eret; EPC = v.epc;
        PC_D = v.pc_d; rs = v.rs; rs_is_ra = v.ra; imm = v.imm;
        ins_index = v.idx; isJr = v.jr; isJal = v.jal;
        isBranch = v.br; isBranchSuccess = v.brs;
        #3;
        chk({tag, ".npc"}, NPC, v.e_npc);
        @(posedge clk);
        #1;
        chk({tag, ".pcf"}, PC_F, v.e_pcf);
        chk({tag, ".cnt"}, 32'(ras_count), 32'(v.e_cnt));
        chk({tag, ".top"}, ras_top, v.e_top);
        chk({tag, ".mm"}, 32'(ras_mismatch), 32'(v.e_mm));
        chk({tag, ".mcnt"}, 32'(mismatch_cnt), 32'(v.e_mcnt));
    endtask

    vec_t tbl [11];
    vec_t v;

    initial begin
        reset = 1; stall = 0; req = 0; eret = 0; EPC = 0; PC_D = 0; rs = 0;
        rs_is_ra = 0; imm = 0; ins_index = 0; isJr = 0; isJal = 0;
        isBranch = 0; isBranchSuccess = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk("rst.pcf", PC_F, 32'h3000);
        chk("rst.cnt", 32'(ras_count), 0);
        chk("rst.mcnt", 32'(mismatch_cnt), 0);
        chk("rst.mm", 32'(ras_mismatch), 0);
        chk("rst.top", ras_top, 0);
        run(nop(32'h3000, 0, 0, 0), "idle0");
        run(nop(32'h3004, 0, 0, 0), "idle1");
        run(nop(32'h3008, 0, 0, 0), "idle2");

        // jal / jr $ra / branches / jr other / priorities / wrap
        tbl[0] = nop(0, 1, 32'h3018, 0);
        tbl[0].jal = 1; tbl[0].pc_d = 32'h3010; tbl[0].idx = 26'h0000C10;
        tbl[0].e_npc = 32'h3040; tbl[0].e_pcf = 32'h3040;
        tbl[1] = nop(0, 0, 0, 0);
        tbl[1].jr = 1; tbl[1].ra = 1; tbl[1].rs = 32'h3018;
        tbl[1].e_npc = 32'h3018; tbl[1].e_pcf = 32'h3018;
        tbl[2] = nop(0, 0, 0, 0);
        tbl[2].br = 1; tbl[2].brs = 1; tbl[2].pc_d = 32'h3020;
        tbl[2].imm = 16'hFFFC;
        tbl[2].e_npc = 32'h3014; tbl[2].e_pcf = 32'h3014;
        tbl[3] = nop(32'h3014, 0, 0, 0);
        tbl[3].br = 1; tbl[3].pc_d = 32'h3020; tbl[3].imm = 16'hFFFC;
        tbl[4] = nop(0, 0, 0, 0);
        tbl[4].jr = 1; tbl[4].rs = 32'h5000;
        tbl[4].e_npc = 32'h5000; tbl[4].e_pcf = 32'h5000;
        tbl[5] = nop(0, 0, 0, 0);
        tbl[5].br = 1; tbl[5].brs = 1; tbl[5].pc_d = 32'h5000;
        tbl[5].imm = 16'h0010;
        tbl[5].e_npc = 32'h5044; tbl[5].e_pcf = 32'h5044;
        tbl[6] = nop(0, 1, 32'h504C, 0);
        tbl[6].jal = 1; tbl[6].br = 1; tbl[6].brs = 1;
        tbl[6].pc_d = 32'h5044; tbl[6].idx = 26'h0001000;
        tbl[6].e_npc = 32'h4000; tbl[6].e_pcf = 32'h4000;
        tbl[7] = nop(0, 2, 32'h8000_0008, 0);
        tbl[7].jal = 1; tbl[7].pc_d = 32'h8000_0000; tbl[7].idx = 26'h10;
        tbl[7].e_npc = 32'h8000_0040; tbl[7].e_pcf = 32'h8000_0040;
        tbl[8] = nop(0, 1, 32'h504C, 0);
        tbl[8].jr = 1; tbl[8].ra = 1; tbl[8].rs = 32'h8000_0008;
        tbl[8].e_npc = 32'h8000_0008; tbl[8].e_pcf = 32'h8000_0008;
        tbl[9] = nop(0, 0, 0, 0);
        tbl[9].jr = 1; tbl[9].ra = 1; tbl[9].rs = 32'h504C;
        tbl[9].e_npc = 32'h504C; tbl[9].e_pcf = 32'h504C;
        tbl[10] = nop(0, 0, 0, 0);
        tbl[10].br = 1; tbl[10].brs = 1; tbl[10].pc_d = 32'hFFFF_FFF0;
        tbl[10].imm = 16'h0004;
        tbl[10].e_npc = 32'h4; tbl[10].e_pcf = 32'h4;
        for (int i = 0; i < 11; i++)
            run(tbl[i], $sformatf("tbl%0d", i));

        // overflow: 9 pushes into 8 entries, then pops until empty
        for (int k = 0; k < 9; k++) begin
            v = nop(0, (k < 8) ? k + 1 : 8, 32'h3008 + 16 * k, 0);
            v.jal = 1; v.pc_d = 32'h3000 + 16 * k; v.idx = 26'h0000C00;
            v.e_npc = 32'h3000; v.e_pcf = 32'h3000;
            run(v, $sformatf("push%0d", k));
        end
        for (int j = 8; j >= 1; j--) begin
            v = nop(0, j - 1, (j > 1) ? 32'h3008 + 16 * (j - 1) : 0, 0);
            v.jr = 1; v.ra = 1; v.rs = 32'h3008 + 16 * j;
            v.e_npc = v.rs; v.e_pcf = v.rs;
            run(v, $sformatf("pop%0d", j));
        end
        v = nop(0, 0, 0, 1);
        v.jr = 1; v.ra = 1; v.rs = 32'h3008;
        v.e_npc = 32'h3008; v.e_pcf = 32'h3008; v.e_mm = 1;
        run(v, "pop_empty");
        run(nop(32'h3008, 0, 0, 1), "mm_clear");

        // non-empty mispredict
        v = nop(0, 1, 32'h3018, 1);
        v.jal = 1; v.pc_d = 32'h3010; v.idx = 26'h0000C10;
        v.e_npc = 32'h3040; v.e_pcf = 32'h3040;
        run(v, "mp_push");
        v = nop(0, 0, 0, 2);
        v.jr = 1; v.ra = 1; v.rs = 32'h3020;
        v.e_npc = 32'h3020; v.e_pcf = 32'h3020; v.e_mm = 1;
        run(v, "mp_pop");

        // stall holds PC and suppresses push; release pushes once
        for (int s = 0; s < 2; s++) begin
            v = nop(0, 0, 0, 2);
            v.stall = 1; v.jal = 1; v.pc_d = 32'h3100; v.idx = 26'h0000D00;
            v.e_npc = 32'h3400; v.e_pcf = 32'h3020;
            run(v, $sformatf("stall%0d", s));
        end
        v = nop(0, 1, 32'h3108, 2);
        v.jal = 1; v.pc_d = 32'h3100; v.idx = 26'h0000D00;
        v.e_npc = 32'h3400; v.e_pcf = 32'h3400;
        run(v, "release");
        run(nop(32'h3400, 1, 32'h3108, 2), "rel_idle");

        // exception during stall, then eret with a jr $ra that must not pop
        v = nop(0, 1, 32'h3108, 2);
        v.stall = 1; v.req = 1; v.jal = 1; v.pc_d = 32'h3200;
        v.idx = 26'h0000E00;
        v.e_npc = 32'h4180; v.e_pcf = 32'h4180;
        run(v, "req");
        v = nop(0, 1, 32'h3108, 2);
        v.stall = 1; v.eret = 1; v.epc = 32'h3050;
        v.jr = 1; v.ra = 1; v.rs = 32'h9999;
        v.e_npc = 32'h3050; v.e_pcf = 32'h3050;
        run(v, "eret");

        // reset while stalled
        stall = 1; reset = 1; isJal = 1;
        @(posedge clk);
        #1;
        reset = 0; stall = 0; isJal = 0;
        chk("rst2.pcf", PC_F, 32'h3000);
        chk("rst2.cnt", 32'(ras_count), 0);
        chk("rst2.mcnt", 32'(mismatch_cnt), 0);
        chk("rst2.top", ras_top, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
